line_drawer: RTL and testbench

Bresenham line rasteriser that responds to line_controller. It latches a pair of endpoints when start is asserted, then emits one pixel coordinate per clock along the line to the VGA framebuffer writer. It reports completion on done. It handles all eight octants, with the colour carried through from the request.

---
 rtl/line_pkg.sv | 24 ++
 rtl/line_drawer.sv | 179 +++++++++++++++++
 tb/tb_line_drawer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_pkg
//  Description : Shared types and constants for the line rasteriser and its
//                controller: coordinate widths, screen size, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package line_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [COORD_W:0] scoord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/line_drawer.sv
`default_nettype none
// ============================================================================
//  Module      : line_drawer
//  Description : Bresenham line rasteriser. Latches two endpoints on start,
//                spends one cycle normalising the line into a shallow,
//                left-to-right form, then emits one pixel per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module line_drawer #(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               color_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               color,
    output logic               plot,
    output logic               done
);

    import line_pkg::*;

    localparam int                 c_SW  = COORD_W + 1;
    localparam logic [COORD_W-1:0] c_ONE = COORD_W'(1);

    draw_state_t r_state;
    draw_state_t w_state_next;

    // Latched request endpoints
    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;

    // Normalised line parameters and the running Bresenham state
    logic                   r_steep;
    logic                   r_ystep_neg;
    logic [COORD_W-1:0]     r_cx, r_cy, r_xb;
    logic signed [c_SW-1:0] r_dx, r_dy, r_err;

    // Setup-cycle normalisation
    logic signed [c_SW-1:0] w_ddx, w_ddy, w_adx, w_ady;
    logic signed [c_SW-1:0] w_dx, w_dyr, w_dy, w_err0;
    logic                   w_steep, w_swap, w_ystep_neg;
    logic [COORD_W-1:0]     w_sxa, w_sya, w_sxb, w_syb;
    logic [COORD_W-1:0]     w_xa, w_ya, w_xb, w_yb;

    // Per-pixel step
    logic signed [c_SW-1:0] w_err_acc, w_err_next;
    logic                   w_ystep_now, w_last;
    logic [COORD_W-1:0]     w_cy_next;

    // Normalise the latched endpoints: make the major axis x, order left to right
    always_comb begin
        w_ddx   = $signed({1'b0, r_x1}) - $signed({1'b0, r_x0});
        w_ddy   = $signed({1'b0, r_y1}) - $signed({1'b0, r_y0});
        w_adx   = w_ddx[c_SW-1] ? -w_ddx : w_ddx;
        w_ady   = w_ddy[c_SW-1] ? -w_ddy : w_ddy;
        w_steep = (w_ady > w_adx);

        w_sxa = w_steep ? r_y0 : r_x0;
        w_sya = w_steep ? r_x0 : r_y0;
        w_sxb = w_steep ? r_y1 : r_x1;
        w_syb = w_steep ? r_x1 : r_y1;

        w_swap = (w_sxa > w_sxb);
        w_xa   = w_swap ? w_sxb : w_sxa;
        w_ya   = w_swap ? w_syb : w_sya;
        w_xb   = w_swap ? w_sxa : w_sxb;
        w_yb   = w_swap ? w_sya : w_syb;

        w_dx        = $signed({1'b0, w_xb}) - $signed({1'b0, w_xa});
        w_dyr       = $signed({1'b0, w_yb}) - $signed({1'b0, w_ya});
        w_dy        = w_dyr[c_SW-1] ? -w_dyr : w_dyr;
        w_ystep_neg = (w_ya > w_yb);
        // dx is never negative, so the arithmetic shift is a plain halving
        w_err0      = -(w_dx >>> 1);
    end

    // Error accumulator step for the pixel currently being emitted
    always_comb begin
        w_err_acc   = r_err + r_dy;
        w_ystep_now = ~w_err_acc[c_SW-1];
        w_err_next  = w_ystep_now ? (w_err_acc - r_dx) : w_err_acc;
        w_cy_next   = r_cy;
        if (w_ystep_now) begin
            w_cy_next = r_ystep_neg ? (r_cy - c_ONE) : (r_cy + c_ONE);
        end
        w_last = (r_cx == r_xb);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a start strobe restarts from any state
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = SETUP;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                SETUP:   w_state_next = DRAW;
                DRAW:    w_state_next = w_last ? IDLE : DRAW;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_steep     <= 1'b0;
            r_ystep_neg <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_xb        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            x           <= '0;
            y           <= '0;
            color       <= 1'b0;
            plot        <= 1'b0;
            done        <= 1'b1;
        end else if (start) begin
            r_x0  <= x0;
            r_y0  <= y0;
            r_x1  <= x1;
            r_y1  <= y1;
            color <= color_in;
            plot  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (r_state)
                SETUP: begin
                    r_steep     <= w_steep;
                    r_ystep_neg <= w_ystep_neg;
                    r_dx        <= w_dx;
                    r_dy        <= w_dy;
                    r_err       <= w_err0;
                    r_cx        <= w_xa;
                    r_cy        <= w_ya;
                    r_xb        <= w_xb;
                    plot        <= 1'b0;
                    done        <= 1'b0;
                end
                DRAW: begin
                    x     <= r_steep ? r_cy : r_cx;
                    y     <= r_steep ? r_cx : r_cy;
                    plot  <= 1'b1;
                    done  <= 1'b0;
                    r_err <= w_err_next;
                    r_cy  <= w_cy_next;
                    r_cx  <= r_cx + c_ONE;
                end
                default: begin
                    plot <= 1'b0;
                    done <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_drawer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_drawer
//  Description : Self-checking bench for line_drawer. Expected pixels are
//                queued when a line is requested; plotted pixels are captured
//                and compared in order once the line completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_drawer;

    localparam int COORD_W = 11;

    logic               clk;
    logic               reset;
    logic               start;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic               color_in;
    logic [COORD_W-1:0] x, y;
    logic               color, plot, done;

    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    logic [22:0] e, g;
    int total;
    int bad;

    line_drawer #(.COORD_W(COORD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .color_in (color_in),
        .x        (x),
        .y        (y),
        .color    (color),
        .plot     (plot),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every plotted pixel, sampled mid-cycle
    always @(negedge clk) begin
        if (plot === 1'b1) got_q.push_back({x, y, color});
    end

    function automatic logic [22:0] pix(input int px, input int py, input logic c);
        logic [10:0] ax;
        logic [10:0] ay;
        ax = px[10:0];
        ay = py[10:0];
        return {ax, ay, c};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input logic c);
        x0 = ax0[10:0];
        y0 = ay0[10:0];
        x1 = ax1[10:0];
        y1 = ay1[10:0];
        color_in = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = 1'b0;
        tick();
        tick();
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot got=%b exp=0", plot); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL reset_done got=%b exp=1", done); end
        total++; if (x !== '0 || y !== '0) begin bad++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", x, y); end
        total++; if (color !== 1'b0) begin bad++; $display("FAIL reset_color got=%b exp=0", color); end
        reset = 1'b1;
        tick();
        total++; if (done !== 1'b1 || plot !== 1'b0) begin bad++; $display("FAIL idle_after_reset done=%b plot=%b exp done=1 plot=0", done, plot); end
        got_q.delete();
    endtask

    task automatic test_horizontal();
        for (int i = 0; i <= 4; i++) exp_q.push_back(pix(i, 0, 1'b1));
        start_line(0, 0, 4, 0, 1'b1);
        total++; if (plot !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL horiz_setup plot=%b done=%b exp plot=0 done=0", plot, done); end
        for (int n = 1; n <= 7; n++) begin
            tick();
            total++;
            if (plot !== (n >= 2 && n <= 6) || done !== (n == 7)) begin
                bad++;
                $display("FAIL horiz_timing cycle=%0d plot=%b done=%b exp plot=%b done=%b", n, plot, done, (n >= 2 && n <= 6), (n == 7));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL horiz_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL horiz_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_diag_reversed();
        for (int i = 0; i <= 3; i++) exp_q.push_back(pix(i, i, 1'b0));
        start_line(3, 3, 0, 0, 1'b0);
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL diag_timeout done=%b exp=1", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL diag_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL diag_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_steep();
        exp_q.push_back(pix(0, 0, 1'b1));
        exp_q.push_back(pix(0, 1, 1'b1));
        exp_q.push_back(pix(1, 2, 1'b1));
        exp_q.push_back(pix(1, 3, 1'b1));
        exp_q.push_back(pix(1, 4, 1'b1));
        start_line(0, 0, 1, 4, 1'b1);
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL steep_timeout done=%b exp=1", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL steep_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL steep_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_negative_slope();
        for (int i = 0; i <= 4; i++) exp_q.push_back(pix(i, 4 - i, 1'b0));
        start_line(0, 4, 4, 0, 1'b0);
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL neg_timeout done=%b exp=1", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL neg_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL neg_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_single_point();
        exp_q.push_back(pix(7, 7, 1'b1));
        start_line(7, 7, 7, 7, 1'b1);
        total++; if (done !== 1'b0 || plot !== 1'b0) begin bad++; $display("FAIL point_setup plot=%b done=%b exp plot=0 done=0", plot, done); end
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++;
            if (plot !== (n == 2) || done !== (n == 3)) begin
                bad++;
                $display("FAIL point_timing cycle=%0d plot=%b done=%b exp plot=%b done=%b", n, plot, done, (n == 2), (n == 3));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL point_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL point_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_restart();
        for (int i = 0; i < 10; i++) exp_q.push_back(pix(i, 0, 1'b1));
        for (int i = 0; i <= 2; i++) exp_q.push_back(pix(0, i, 1'b0));
        start_line(0, 0, 639, 0, 1'b1);
        for (int i = 0; i < 100 && got_q.size() < 10; i++) tick();
        total++; if (got_q.size() != 10) begin bad++; $display("FAIL restart_first10 got=%0d exp=10", got_q.size()); end
        start_line(0, 0, 0, 2, 1'b0);
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_timeout done=%b exp=1", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL restart_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL restart_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(pix(i, 0, 1'b1));
        start_line(0, 0, 639, 0, 1'b1);
        for (int i = 0; i < 100 && got_q.size() < 10; i++) tick();
        // Clock is low here and the next rising edge is several time units away
        #2;
        reset = 1'b0;
        #1;
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL areset_plot got=%b exp=0", plot); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL areset_done got=%b exp=1", done); end
        total++; if (x !== '0 || y !== '0) begin bad++; $display("FAIL areset_xy got=(%0d,%0d) exp=(0,0)", x, y); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        total++; if (plot !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL areset_idle plot=%b done=%b exp plot=0 done=1", plot, done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL areset_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL areset_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        // Start held high: the request is re-latched every edge, nothing is drawn
        x0 = 11'd2; y0 = 11'd1; x1 = 11'd5; y1 = 11'd3; color_in = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (plot !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL held_start cycle=%0d plot=%b done=%b exp plot=0 done=0", n, plot, done);
            end
        end
        start = 1'b0;
        exp_q.push_back(pix(2, 1, 1'b1));
        exp_q.push_back(pix(3, 2, 1'b1));
        exp_q.push_back(pix(4, 3, 1'b1));
        exp_q.push_back(pix(5, 3, 1'b1));
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL held_timeout done=%b exp=1", done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL held_pix got=(%0d,%0d,c%b) exp=(%0d,%0d,c%b)", g[22:12], g[11:1], g[0], e[22:12], e[11:1], e[0]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL held_extra got=%0d extra pixels exp=0", got_q.size()); end
        got_q.delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_horizontal();
        test_diag_reversed();
        test_steep();
        test_negative_slope();
        test_single_point();
        test_restart();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
